// File: rtl/mux_scan_serializer.sv
// Sequenced source/sink for a combinational n:1 mux: latches a parallel word,
// walks the select across every input and returns the mux output LSB-first.
module mux_scan_serializer #(
    parameter  int inputs = 4,
    localparam int SEL_W  = $clog2(inputs)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              load_in,
    input  logic [inputs-1:0] data_in,
    output logic              ready_out,
    input  logic              hold_in,
    output logic [inputs-1:0] w_out,
    output logic [SEL_W-1:0]  s_out,
    input  logic              f_in,
    output logic              serial_out,
    output logic              serial_valid_out,
    output logic              last_out
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(inputs - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    // One-hot-style encoding leaves spare codes so a corrupted state is recoverable.
    typedef enum logic [1:0] {
        IDLE = 2'b01,
        SCAN = 2'b10
    } state_t;

    state_t             state, state_d;
    logic [inputs-1:0]  w_d;
    logic [SEL_W-1:0]   s_d;
    logic               serial_d;
    logic               valid_d;
    logic               last_d;

    assign ready_out = (state == IDLE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= IDLE;
            w_out            <= '0;
            s_out            <= '0;
            serial_out       <= 1'b0;
            serial_valid_out <= 1'b0;
            last_out         <= 1'b0;
        end else begin
            state            <= state_d;
            w_out            <= w_d;
            s_out            <= s_d;
            serial_out       <= serial_d;
            serial_valid_out <= valid_d;
            last_out         <= last_d;
        end
    end

    always_comb begin
        state_d  = state;
        w_d      = w_out;
        s_d      = s_out;
        serial_d = serial_out;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        case (state)
            IDLE: begin
                s_d = '0;
                if (load_in) begin
                    w_d     = data_in;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!hold_in) begin
                    serial_d = f_in;
                    valid_d  = 1'b1;
                    // Explicit wrap keeps unused select codes off the mux for non-power-of-two widths.
                    if (s_out == SEL_LAST) begin
                        last_d  = 1'b1;
                        s_d     = '0;
                        state_d = IDLE;
                    end else begin
                        s_d = s_out + SEL_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
            end
        endcase
    end

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
- Upstream driver for mux_generic_1bit.
- Accepts an n-bit parallel word through a valid/ready handshake and holds it on the mux data bus. Steps the mux select from 0 to inputs-1, one position per enabled cycle.
- Registers the mux output f back in as an LSB-first serial bit stream with valid/last flags.
- Gives the mux a self-checking, sequenced source/sink, so the combinational mux runs inside a clocked datapath.

Parameters:
inputs, 4, number of mux data inputs / word width; legal range 2..64, need not be a power of two
SEL_W, $clog2(inputs), select width (derived localparam, not overridable)

Ports:
clk_in  input  1  rising-edge clock
rst_n_in  input  1  asynchronous active-low reset
load_in  input  1  word valid; accepted when load_in && ready_out at a rising edge
data_in  input  inputs  parallel word to serialize
ready_out  output  1  block idle and able to accept a word
hold_in  input  1  pause stepping while high (SCAN only)
w_out  output  inputs  to mux w_in: latched word
s_out  output  SEL_W  to mux s_in: current select
f_in  input  1  from mux f_out (combinational return path)
serial_out  output  1  registered sampled mux output
serial_valid_out  output  1  serial_out holds a new bit this cycle
last_out  output  1  accompanies final bit of the word (index inputs-1)

Behaviour:
- Reset (async, rst_n_in=0): state=IDLE, w_out=0, s_out=0, serial_out=0, serial_valid_out=0, last_out=0, ready_out=1. Release is synchronous to the next clk_in edge.
- ready_out is decoded from registered state: 1 in IDLE only.
- States: IDLE, SCAN. No other states; any illegal encoding returns to IDLE.
- IDLE: s_out=0; w_out keeps its last value. Edge with load_in=1 -> w_out<=data_in, s_out<=0, state<=SCAN. load_in=0 -> stay.
- SCAN, hold_in=0, at edge:
  - serial_out<=f_in, serial_valid_out<=1.
  - If s_out==inputs-1: last_out<=1, s_out<=0, state<=IDLE.
  - Else: s_out<=s_out+1, last_out<=0.
- SCAN, hold_in=1: s_out, w_out and state frozen; serial_valid_out<=0, last_out<=0; serial_out keeps its value.
- serial_valid_out and last_out are single-cycle pulses per captured bit. Both are 0 in any cycle with no capture, including all IDLE cycles.
- Timing, load accepted at edge E0, no hold:
  - Bit k (=data_in[k]) appears on serial_out after edge E(k+1) with serial_valid_out=1.
  - last_out=1 after E(inputs); ready_out=1 after E(inputs).
  - Earliest next load is edge E(inputs+1). Throughput is one word per inputs+1 cycles.
- load_in during SCAN is ignored: data_in is not sampled and the in-flight word is not disturbed.
- hold_in in IDLE has no effect.
- hold_in asserted on the cycle that would capture the last bit delays last_out and the IDLE return until hold drops.
- Select never exceeds inputs-1 (wrap is explicit, not modulo 2^SEL_W). For non-power-of-two inputs the unused select codes are never driven.
- Reset mid-SCAN aborts immediately: outputs take reset values and no partial last_out is issued.
- f_in is sampled only at SCAN capture edges. f_in value in IDLE is don't-care.

Test Plan:
1. Reset then idle 3 cycles -> ready_out=1, s_out=0, w_out=4'b0000, serial_valid_out=0, last_out=0.
2. inputs=4, load 4'b1011 with hold_in=0, mux in loop:
   - serial_out = 1,1,0,1 on cycles E1..E4, serial_valid_out=1 on each.
   - s_out = 0,1,2,3 during those cycles.
   - last_out=1 only with E4; ready_out=1 after E4.
3. Load 4'b0110; hold_in=1 for 2 cycles after E1 -> serial_out stays 0, valid=0 during hold, s_out stays 1; then bits 1,1,0 follow, last_out with bit 3 at E6.
4. Load 4'b1110, pulse load_in with 4'b0001 mid-scan -> ignored; stream stays 0,1,1,1. Second load at E5 accepted; stream 1,0,0,0.
5. Load 4'b1101, assert rst_n_in=0 asynchronously between E2 and E3 -> all outputs reset instantly, no last_out. After release, load 4'b0010 streams 0,1,0,0.
6. inputs=3, load 3'b101 -> s_out sequence 0,1,2 then 0, never 3; serial 1,0,1 with last_out on third bit.
